dmem_responder: RTL and testbench

- Data-memory responder: the target end of the core's load/store port, serving requests issued from the MEM stage.
- Accepts one request at a time over a valid/ready handshake and holds it for a fixed, parameterised latency.
- Performs byte/half/word reads and writes, little-endian, with sign or zero extension on reads.
- Returns a response over a second valid/ready handshake. Used as the multi-cycle memory model behind the pipelined core.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_lane_unit.sv | 49 ++++
 rtl/dmem_responder.sv | 138 +++++++++++++
 tb/tb_dmem_responder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access size codes,
// FSM state encoding and the default data-memory base address.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h0100_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane steering for one 32-bit word: store merge, load extraction with
// sign/zero extension, and natural-alignment check.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [31:0] stored,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] wmerge,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Lane select, merge and extension by access size; size 11 leaves the word untouched
    always_comb begin
        wmerge   = stored;
        rdata    = 32'h0000_0000;
        misalign = 1'b0;
        byte_val = stored[{addr_lo, 3'b000} +: 8];
        half_val = stored[{addr_lo[1], 4'b0000} +: 16];
        case (size)
            SIZE_BYTE: begin
                wmerge[{addr_lo, 3'b000} +: 8] = wdata[7:0];
                rdata = {{24{~is_unsigned & byte_val[7]}}, byte_val};
            end
            SIZE_HALF: begin
                misalign = addr_lo[0];
                wmerge[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
                rdata = {{16{~is_unsigned & half_val[15]}}, half_val};
            end
            SIZE_WORD: begin
                misalign = (addr_lo != 2'b00);
                wmerge   = wdata;
                rdata    = stored;
            end
            default: begin
                wmerge   = stored;
                rdata    = 32'h0000_0000;
                misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: accepts one load/store at a time, commits it
// after a fixed latency and returns the response over a valid/ready handshake.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int                 DATAW       = 32,
    parameter logic [DATAW-1:0]   BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int                 DEPTH_WORDS = 1024,
    parameter int                 LATENCY     = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rw,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [DATAW-1:0] req_addr,
    input  logic [DATAW-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DATAW-1:0] rsp_rdata,
    output logic             rsp_err
);

    localparam int IDXW = $clog2(DEPTH_WORDS);
    localparam logic [DATAW:0] END_ADDR = {1'b0, BASE_ADDR} + (DATAW+1)'(4 * DEPTH_WORDS);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 1..15");
    end
    if (DATAW != 32) begin : g_bad_width
        $error("dmem_responder: DATAW must be 32");
    end

    state_t           state;
    logic [3:0]       cnt;
    logic             cap_rw;
    logic [1:0]       cap_size;
    logic             cap_unsigned;
    logic [DATAW-1:0] cap_addr;
    logic [DATAW-1:0] cap_wdata;

    logic [31:0]      mem [0:DEPTH_WORDS-1];

    logic [DATAW-1:0] offset;
    logic [IDXW-1:0]  idx;
    logic             in_range;
    logic             err;
    logic             commit;
    logic [31:0]      stored;
    logic [31:0]      wmerge;
    logic [31:0]      rdata_ext;
    logic             misalign;

    assign offset   = cap_addr - BASE_ADDR;
    assign idx      = IDXW'(offset >> 2);
    assign in_range = (cap_addr >= BASE_ADDR) && ({1'b0, cap_addr} < END_ADDR);
    assign stored   = mem[idx];
    assign err      = !in_range || misalign || (cap_size == 2'b11);
    assign commit   = (state == WAIT) && (cnt == 4'd0);

    dmem_lane_unit u_lane (
        .stored      (stored),
        .addr_lo     (cap_addr[1:0]),
        .size        (cap_size),
        .is_unsigned (cap_unsigned),
        .wdata       (cap_wdata),
        .wmerge      (wmerge),
        .rdata       (rdata_ext),
        .misalign    (misalign)
    );

    // Storage array: written only on an error-free store commit, never reset
    always_ff @(posedge clock) begin
        if (commit && cap_rw && !err) begin
            mem[idx] <= wmerge;
        end
    end

    // Request/response FSM with latency counter and registered handshake outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            cap_rw       <= 1'b0;
            cap_size     <= 2'b00;
            cap_unsigned <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_rw       <= req_rw;
                        cap_size     <= req_size;
                        cap_unsigned <= req_unsigned;
                        cap_addr     <= req_addr;
                        cap_wdata    <= req_wdata;
                        cnt          <= 4'(LATENCY - 1);
                        req_ready    <= 1'b0;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        rsp_rdata <= (err || cap_rw) ? '0 : rdata_ext;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // req_ready reappears only after the handshake edge, never alongside it
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with LATENCY=2.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(
        .DATAW       (32),
        .BASE_ADDR   (32'h0100_0000),
        .DEPTH_WORDS (1024),
        .LATENCY     (LAT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rw       (req_rw),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction; hold = cycles rsp_ready stays low while RESP is shown
    task automatic xact(input string tag, input logic rw, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int cyc;
        logic [31:0] held_rdata;
        logic        held_err;
        @(negedge clock);
        check_eq({tag, "_req_ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_rw = rw; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clock); #1;
        req_valid = 1'b0; req_rw = ~rw; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clock); #1;
            cyc++;
        end
        check_eq({tag, "_latency"}, cyc, LAT);
        check_eq({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check_eq({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        held_rdata = rsp_rdata;
        held_err   = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check_eq({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            check_eq({tag, "_hold_rdata"}, rsp_rdata, held_rdata);
            check_eq({tag, "_hold_err"}, {31'd0, rsp_err}, {31'd0, held_err});
            check_eq({tag, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
        end
        check_eq({tag, "_req_ready_busy"}, {31'd0, req_ready}, 32'd0);
        @(negedge clock);
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        check_eq({tag, "_post_valid"}, {31'd0, rsp_valid}, 32'd0);
        check_eq({tag, "_post_req_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // word write/read and extensions
        xact("wr_word",   1'b1, 2'b10, 1'b0, 32'h0100_0010, 32'hDEAD_BEEF, 0, 32'h0000_0000, 1'b0);
        xact("rd_word",   1'b0, 2'b10, 1'b0, 32'h0100_0010, 32'h0,         0, 32'hDEAD_BEEF, 1'b0);
        xact("rd_byte_u", 1'b0, 2'b00, 1'b1, 32'h0100_0011, 32'h0,         0, 32'h0000_00BE, 1'b0);
        xact("rd_byte_s", 1'b0, 2'b00, 1'b0, 32'h0100_0011, 32'h0,         0, 32'hFFFF_FFBE, 1'b0);

        // half merge, half reads
        xact("wr_half",   1'b1, 2'b01, 1'b0, 32'h0100_0012, 32'h0000_1234, 0, 32'h0000_0000, 1'b0);
        xact("rd_merged", 1'b0, 2'b10, 1'b0, 32'h0100_0010, 32'h0,         0, 32'h1234_BEEF, 1'b0);
        xact("rd_half_s", 1'b0, 2'b01, 1'b0, 32'h0100_0010, 32'h0,         0, 32'hFFFF_BEEF, 1'b0);
        xact("rd_half_u", 1'b0, 2'b01, 1'b1, 32'h0100_0010, 32'h0,         0, 32'h0000_BEEF, 1'b0);
        xact("rd_half_hi",1'b0, 2'b01, 1'b0, 32'h0100_0012, 32'h0,         0, 32'h0000_1234, 1'b0);

        // byte write into top lane
        xact("wr_byte",   1'b1, 2'b00, 1'b0, 32'h0100_0013, 32'hFFFF_FF77, 0, 32'h0000_0000, 1'b0);
        xact("rd_after_b",1'b0, 2'b10, 1'b0, 32'h0100_0010, 32'h0,         0, 32'h7734_BEEF, 1'b0);

        // error cases
        xact("wr_base",   1'b1, 2'b10, 1'b0, 32'h0100_0000, 32'hA5A5_A5A5, 0, 32'h0000_0000, 1'b0);
        xact("wr_misal",  1'b1, 2'b10, 1'b0, 32'h0100_0002, 32'h1111_1111, 0, 32'h0000_0000, 1'b1);
        xact("rd_base",   1'b0, 2'b10, 1'b0, 32'h0100_0000, 32'h0,         0, 32'hA5A5_A5A5, 1'b0);
        xact("rd_below",  1'b0, 2'b10, 1'b0, 32'h00FF_FFFC, 32'h0,         0, 32'h0000_0000, 1'b1);
        xact("rd_above",  1'b0, 2'b10, 1'b0, 32'h0100_1000, 32'h0,         0, 32'h0000_0000, 1'b1);
        xact("wr_last",   1'b1, 2'b10, 1'b0, 32'h0100_0FFC, 32'h0BAD_F00D, 0, 32'h0000_0000, 1'b0);
        xact("rd_last",   1'b0, 2'b10, 1'b0, 32'h0100_0FFC, 32'h0,         0, 32'h0BAD_F00D, 1'b0);
        xact("rd_size11", 1'b0, 2'b11, 1'b0, 32'h0100_0010, 32'h0,         0, 32'h0000_0000, 1'b1);
        xact("rd_half_mis",1'b0,2'b01, 1'b0, 32'h0100_0011, 32'h0,         0, 32'h0000_0000, 1'b1);

        // backpressure
        xact("rd_bp",     1'b0, 2'b10, 1'b0, 32'h0100_0010, 32'h0,         5, 32'h7734_BEEF, 1'b0);

        // reset while a write waits
        xact("wr_prior",  1'b1, 2'b10, 1'b0, 32'h0100_0020, 32'h1122_3344, 0, 32'h0000_0000, 1'b0);
        @(negedge clock);
        req_valid = 1'b1; req_rw = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0100_0020; req_wdata = 32'hCAFE_F00D;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check_eq("rstw_valid_async", {31'd0, rsp_valid}, 32'd0);
        check_eq("rstw_ready_async", {31'd0, req_ready}, 32'd1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
            check_eq("rstw_valid_after", {31'd0, rsp_valid}, 32'd0);
            check_eq("rstw_ready_after", {31'd0, req_ready}, 32'd1);
        end
        xact("rd_after_rst",1'b0,2'b10, 1'b0, 32'h0100_0020, 32'h0,        0, 32'h1122_3344, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
